// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache miss-path arbiter onto one shared RAM port
// Data cache has priority; a saturating streak counter forces an icache grant.
module cache_mem_arbiter #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          dreq;
  logic          access;

  assign dreq   = dREN | dWEN;
  assign access = (ramstate == RAM_ACCESS);

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state_q)
      IDLE: begin
        if (iREN && (!dreq || streak_q == SMAX)) state_d = SERVE_I;
        else if (dreq)                            state_d = SERVE_D;
      end
      SERVE_I: begin
        // A withdrawn request ends the grant without touching the streak.
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (access) begin
            iwait    = 1'b0;
            iload    = ramload;
            state_d  = IDLE;
            streak_d = '0;
          end
        end
      end
      SERVE_D: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = ~dWEN;
          if (access) begin
            dwait   = 1'b0;
            dload   = dWEN ? '0 : ramload;
            state_d = IDLE;
            if (iREN) streak_d = (streak_q == SMAX) ? SMAX : streak_q + 1'b1;
            else      streak_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(.WORD_W(32), .STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".iwait"}, {31'd0, iwait}, 32'd1);
    check({tag, ".dwait"}, {31'd0, dwait}, 32'd1);
    check({tag, ".iload"}, iload, 32'd0);
    check({tag, ".dload"}, dload, 32'd0);
    check({tag, ".ramREN"}, {31'd0, ramREN}, 32'd0);
    check({tag, ".ramWEN"}, {31'd0, ramWEN}, 32'd0);
    check({tag, ".ramaddr"}, ramaddr, 32'd0);
    check({tag, ".ramstore"}, ramstore, 32'd0);
  endtask

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
    #3;
    check_reset_outputs("rst0");
    #4 nRST = 1'b1;

    // single icache read, ACCESS on the third serve cycle
    cyc();
    iREN = 1; iaddr = 32'h40; ramstate = 2'd1; ramload = 32'hDEADBEEF;
    #1;
    check("i.idle_ren", {31'd0, ramREN}, 32'd0);
    cyc(); #1;
    check("i.c1_addr", ramaddr, 32'h40);
    check("i.c1_ren", {31'd0, ramREN}, 32'd1);
    check("i.c1_wait", {31'd0, iwait}, 32'd1);
    check("i.c1_load", iload, 32'd0);
    cyc(); #1;
    check("i.c2_wait", {31'd0, iwait}, 32'd1);
    cyc();
    ramstate = 2'd2;
    #1;
    check("i.c3_wait", {31'd0, iwait}, 32'd0);
    check("i.c3_load", iload, 32'hDEADBEEF);
    cyc();
    iREN = 0;
    #1;
    check("i.after_wait", {31'd0, iwait}, 32'd1);
    check("i.after_ren", {31'd0, ramREN}, 32'd0);

    // priority: dcache first, IDLE bubble, then icache
    iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h100; ramload = 32'hA5A5_0001;
    cyc(); #1;
    check("p.d_addr", ramaddr, 32'h100);
    check("p.d_ren", {31'd0, ramREN}, 32'd1);
    check("p.d_wait", {31'd0, dwait}, 32'd0);
    check("p.d_load", dload, 32'hA5A5_0001);
    check("p.i_wait_hi", {31'd0, iwait}, 32'd1);
    dREN = 0;
    cyc(); #1;
    check("p.bubble_ren", {31'd0, ramREN}, 32'd0);
    cyc(); #1;
    check("p.i_addr", ramaddr, 32'h44);
    check("p.i_wait", {31'd0, iwait}, 32'd0);
    iREN = 0;
    cyc(); #1;

    // anti-starvation: D,D,D,D,I,D,D,D,D,I with both requests held
    iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h300;
    for (int k = 0; k < 10; k++) begin
      cyc(); #1;
      check($sformatf("s.grant%0d", k), ramaddr, (k % 5 == 4) ? 32'h200 : 32'h300);
      check($sformatf("s.ren%0d", k), {31'd0, ramREN}, 32'd1);
      cyc(); #1;
      check($sformatf("s.bubble%0d", k), {31'd0, ramREN}, 32'd0);
    end
    iREN = 0; dREN = 0;
    cyc(); #1;

    // write wins over read; dload stays 0 on writes
    dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
    ramstate = 2'd1; ramload = 32'h5555;
    cyc(); #1;
    check("w.wen", {31'd0, ramWEN}, 32'd1);
    check("w.ren", {31'd0, ramREN}, 32'd0);
    check("w.store", ramstore, 32'h1234);
    check("w.addr", ramaddr, 32'h80);
    check("w.busy_wait", {31'd0, dwait}, 32'd1);
    ramstate = 2'd2;
    #1;
    check("w.acc_wait", {31'd0, dwait}, 32'd0);
    check("w.acc_load", dload, 32'd0);
    dREN = 0; dWEN = 0;
    cyc(); #1;

    // withdrawal mid-grant
    dWEN = 1; ramstate = 2'd1;
    cyc(); #1;
    check("x.wen_on", {31'd0, ramWEN}, 32'd1);
    dWEN = 0;
    #1;
    check("x.wen_drop", {31'd0, ramWEN}, 32'd0);
    cyc();
    dWEN = 1;
    #1;
    check("x.idle_after", {31'd0, ramWEN}, 32'd0);

    // ERROR holds the grant and never completes
    ramstate = 2'd3;
    for (int k = 0; k < 10; k++) begin
      cyc(); #1;
      check($sformatf("e.dwait%0d", k), {31'd0, dwait}, 32'd1);
      check($sformatf("e.wen%0d", k), {31'd0, ramWEN}, 32'd1);
    end

    // asynchronous reset mid SERVE_D
    nRST = 1'b0;
    #1;
    check("r.wen", {31'd0, ramWEN}, 32'd0);
    check("r.dwait", {31'd0, dwait}, 32'd1);
    dWEN = 0; ramstate = 2'd0;
    #1 nRST = 1'b1;
    #1;
    check_reset_outputs("r.rel");
    cyc();
    check_reset_outputs("r.hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the instruction cache and data cache miss paths onto the single shared RAM port. Sits between the caches' memory-side signals (`iREN/iaddr/iwait/iload`, `dREN/dWEN/daddr/dstore/dwait/dload`) and the RAM. It serialises accesses with an explicit grant FSM. The data cache has priority, bounded by an anti-starvation counter so instruction fetch always progresses.

## Interface
- `WORD_W`, 32, data/address width
- `STARVE_MAX`, 4, max consecutive completed dcache grants while `iREN` is pending before icache is forced (≥1)
- `CLK`  in  1  clock, rising edge
- `nRST`  in  1  asynchronous, active-low reset
- `iREN`  in  1  icache read request
- `iaddr`  in  WORD_W  icache address
- `iwait`  out  1  low for exactly the cycle icache data is valid
- `iload`  out  WORD_W  icache read data
- `dREN`  in  1  dcache read request
- `dWEN`  in  1  dcache write request
- `daddr`  in  WORD_W  dcache address
- `dstore`  in  WORD_W  dcache write data
- `dwait`  out  1  low for exactly the cycle the dcache access completes
- `dload`  out  WORD_W  dcache read data
- `ramREN`  out  1  RAM read enable
- `ramWEN`  out  1  RAM write enable
- `ramaddr`  out  WORD_W  RAM address
- `ramstore`  out  WORD_W  RAM write data
- `ramload`  in  WORD_W  RAM read data
- `ramstate`  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

## Operation
- The FSM has three states: IDLE, SERVE_I, SERVE_D. `dreq = dREN | dWEN`.
- In IDLE, no RAM enables are driven and both waits are high. Next-state selection:
  - `iREN & (~dreq | streak==STARVE_MAX)` → SERVE_I
  - else `dreq` → SERVE_D
  - else stay in IDLE.
- In SERVE_I:
  - Drive `ramREN=1`, `ramWEN=0`, `ramaddr=iaddr`, `ramstore=0`.
  - On `ramstate==ACCESS`: `iwait=0`, `iload=ramload`, next state IDLE, `streak←0`.
- In SERVE_D:
  - Drive `ramaddr=daddr` and `ramstore=dstore`.
  - If `dWEN` is high, drive `ramWEN=1`, `ramREN=0`. `dWEN` wins when both `dWEN` and `dREN` are high.
  - Otherwise drive `ramREN=1`, `ramWEN=0`.
  - On ACCESS: `dwait=0`, `dload=ramload` (reads only; 0 on writes), next state IDLE.
  - Also on ACCESS, if `iREN` is high that cycle, `streak←min(streak+1, STARVE_MAX)`; otherwise `streak←0`.
- FREE, BUSY and ERROR all count as not done. The arbiter holds the grant and keeps the waits high. ERROR never completes an access; recovery is by reset.
- Request withdrawn mid-grant: if the served requester's enable(s) drop while in SERVE_x, the RAM enables drop in the same cycle (combinational), next state IDLE, and `streak` is unchanged.
- `iload` and `dload` are 0 whenever their wait is high.
- `streak` is `$clog2(STARVE_MAX+1)` bits wide, saturating, and never wraps.

## Timing
- Reset (asynchronous, while `nRST=0`): state IDLE, `streak=0`. Outputs are `iwait=1`, `dwait=1`, `iload=0`, `dload=0`, `ramREN=0`, `ramWEN=0`, `ramaddr=0`, `ramstore=0`. Reset mid-grant aborts the access immediately.
- State and `streak` are registered. All outputs are combinational from state and inputs.
- Arbitration latency: a request seen in IDLE at edge N drives the RAM from cycle N+1.
- Minimum access time is 2 cycles (IDLE + SERVE with ACCESS in the first serve cycle). There is one mandatory IDLE bubble between consecutive grants.
- Waits go low for one cycle only, in the ACCESS cycle. The requester is expected to drop or change its request on the next edge.
- Simultaneous `iREN` and `dreq` in IDLE: dcache wins unless `streak==STARVE_MAX`.
- `ramstate` changing from ACCESS back to BUSY within a grant is not possible, because the grant ends on the first ACCESS.

## Test plan
- **Reset values:** assert `nRST=0` mid-SERVE_D → `ramWEN=0`, `dwait=1`, state IDLE immediately. Release reset, all outputs hold their reset values.
- **Single icache read:** `iREN=1`, `iaddr=0x40`, RAM ACCESS on the 3rd serve cycle with `ramload=0xDEADBEEF` → `ramaddr=0x40` from cycle 1. `iwait` is low only in cycle 3, with `iload=0xDEADBEEF`.
- **Priority:** `iREN` and `dREN` raised together, RAM ACCESS every serve cycle → dcache served first (`ramaddr=daddr`), then IDLE, then icache.
- **Anti-starvation with `STARVE_MAX=4`:** hold `iREN` and `dREN` high continuously, RAM always ACCESS → grant sequence D,D,D,D,I,D,D,D,D,I.
- **Write precedence:** `dREN=dWEN=1`, `daddr=0x80`, `dstore=0x1234` → `ramWEN=1`, `ramREN=0`, `ramstore=0x1234`; `dload=0` on completion.
- **Withdrawal/ERROR:** in SERVE_D drop `dWEN` → RAM enables fall the same cycle, next state IDLE. With `ramstate=ERROR` for 10 cycles, `dwait` stays 1 throughout and the grant is held.
